// File: rtl/exe_div_unit.sv
// Execute-stage operand forwarding mux plus a 32-iteration radix-2 restoring
// divider (DIV/DIVU) that stalls the pipeline until HI/LO are ready.
module exe_div_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  EXE_ForwardA,
  input  logic [1:0]  EXE_ForwardB,
  input  logic [31:0] EXE_BusA,
  input  logic [31:0] EXE_BusB,
  input  logic [31:0] MEM_Result,
  input  logic [31:0] WB_Result,
  input  logic        EXE_DivStart,
  input  logic        EXE_DivSigned,
  input  logic        EXE_Flush,
  output logic [31:0] EXE_SrcA,
  output logic [31:0] EXE_SrcB,
  output logic        DIV_Busy,
  output logic        DIV_Done,
  output logic [31:0] DIV_Hi,
  output logic [31:0] DIV_Lo
);

  localparam int CW = $clog2(DIV_ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     rem_q, quo_q, dvsr_q;
  logic            qsign_q, rsign_q;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     rem_d, quo_d;
  logic [32:0]     rem_sh, rem_sub;
  logic            ge;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return cond_neg(v, sgn & v[31]);
  endfunction

  always_comb begin
    case (EXE_ForwardA)
      2'b01:   EXE_SrcA = MEM_Result;
      2'b10:   EXE_SrcA = WB_Result;
      default: EXE_SrcA = EXE_BusA;
    endcase
    case (EXE_ForwardB)
      2'b01:   EXE_SrcB = MEM_Result;
      2'b10:   EXE_SrcB = WB_Result;
      default: EXE_SrcB = EXE_BusB;
    endcase
  end

  // One restoring step: the shifted remainder needs 33 bits because it can
  // reach 2*divisor-1 when the divisor has its MSB set.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    rem_sub = rem_sh - {1'b0, dvsr_q};
    ge      = (rem_sh >= {1'b0, dvsr_q});
    rem_d   = ge ? rem_sub[31:0] : rem_sh[31:0];
    quo_d   = {quo_q[30:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EXE_DivStart && !EXE_Flush) begin
            quo_q   <= magnitude(EXE_SrcA, EXE_DivSigned);
            dvsr_q  <= magnitude(EXE_SrcB, EXE_DivSigned);
            qsign_q <= EXE_DivSigned & (EXE_SrcA[31] ^ EXE_SrcB[31]);
            rsign_q <= EXE_DivSigned & EXE_SrcA[31];
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (EXE_Flush) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DIV_ITER - 1))
              state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!EXE_Flush) begin
            lo_q <= cond_neg(quo_q, qsign_q);
            hi_q <= cond_neg(rem_q, rsign_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A flush landing in the DONE cycle suppresses the completion pulse.
  assign DIV_Busy = ((state_q == S_IDLE) && EXE_DivStart && !EXE_Flush) ||
                    (state_q == S_CALC);
  assign DIV_Done = (state_q == S_DONE) && !EXE_Flush;
  assign DIV_Hi   = hi_q;
  assign DIV_Lo   = lo_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed self-checking bench for exe_div_unit: forwarding mux, divide
// timing and results, divide-by-zero, overflow case, flush and reset.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] bus_a, bus_b, mem_res, wb_res;
  logic        start, sgn, flush;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_div_unit #(.DIV_ITER(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .EXE_ForwardA (fwd_a),
    .EXE_ForwardB (fwd_b),
    .EXE_BusA     (bus_a),
    .EXE_BusB     (bus_b),
    .MEM_Result   (mem_res),
    .WB_Result    (wb_res),
    .EXE_DivStart (start),
    .EXE_DivSigned(sgn),
    .EXE_Flush    (flush),
    .EXE_SrcA     (src_a),
    .EXE_SrcB     (src_b),
    .DIV_Busy     (busy),
    .DIV_Done     (done),
    .DIV_Hi       (hi),
    .DIV_Lo       (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0, check Busy over cycles 0..32, Done in 33, result in 34.
  // Bus values are scrambled during CALC to prove operands were latched.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int busy_bad;
    fwd_a = 2'b00; fwd_b = 2'b00;
    bus_a = a; bus_b = b; sgn = s; start = 1'b1; flush = 1'b0;
    #1;
    chk({tag, "_busy_c0"}, {31'd0, busy}, 32'd1);
    busy_bad = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      bus_a = ~a; bus_b = b + 32'd3;
      #1;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    chk({tag, "_busy_calc_errs"}, busy_bad, 32'd0);
    tick();
    chk({tag, "_done_c33"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_c33"}, {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();
    chk({tag, "_done_c34"}, {31'd0, done}, 32'd0);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00;
    bus_a = 32'd0; bus_b = 32'd0; mem_res = 32'd0; wb_res = 32'd0;
    start = 1'b0; sgn = 1'b0; flush = 1'b0;
    #2;
    chk("rst_hi",   hi, 32'd0);
    chk("rst_lo",   lo, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Forwarding mux
    bus_a = 32'd1; mem_res = 32'd2; wb_res = 32'd3; bus_b = 32'd1;
    fwd_a = 2'b00; #1 chk("srca_00", src_a, 32'd1);
    fwd_a = 2'b01; #1 chk("srca_01", src_a, 32'd2);
    fwd_a = 2'b10; #1 chk("srca_10", src_a, 32'd3);
    fwd_a = 2'b11; #1 chk("srca_11", src_a, 32'd1);
    fwd_b = 2'b00; #1 chk("srcb_00", src_b, 32'd1);
    fwd_b = 2'b01; #1 chk("srcb_01", src_b, 32'd2);
    fwd_b = 2'b10; #1 chk("srcb_10", src_b, 32'd3);
    fwd_b = 2'b11; #1 chk("srcb_11", src_b, 32'd1);
    tick();

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_div("div_m7_2",   32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",   32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_div("div_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_div("divu_5_0",   32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);

    // Flush at cycle 10: back to IDLE at 11, no Done, Hi/Lo untouched
    bus_a = 32'd100; bus_b = 32'd7; sgn = 1'b0; start = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    #1 chk("flush_busy_c10", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b0; start = 1'b0;
    #1 chk("flush_busy_c11", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("flush_no_activity", seen, 32'd0);
    chk("flush_keep_lo", lo, 32'hFFFF_FFFF);
    chk("flush_keep_hi", hi, 32'd5);

    // Start and flush coincide: nothing begins
    bus_a = 32'd9; bus_b = 32'd3; start = 1'b1; flush = 1'b1;
    #1 chk("sf_busy_c0", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1 chk("sf_busy_c1", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 35; c++) begin
      tick();
      if (done !== 1'b0) seen++;
    end
    chk("sf_no_done", seen, 32'd0);
    chk("sf_keep_lo", lo, 32'hFFFF_FFFF);

    // Asynchronous reset in cycle 15 of an operation
    bus_a = 32'd100; bus_b = 32'd7; sgn = 1'b0; start = 1'b1;
    repeat (15) tick();
    #2;
    resetn = 1'b0; start = 1'b0;
    #1;
    chk("mrst_hi",   hi, 32'd0);
    chk("mrst_lo",   lo, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_div("post_rst_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
